fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
//  Downstream drain stage for fifo_ram_sym: pops words from the FIFO read side
//  and presents them on a valid/ready stream with a 2-entry output buffer.
//  Sustains one word per cycle, keeps m_ready off the fifo_r_en path and
//  marks packet boundaries (m_last) every PKT_LEN words.
// PARAMETERS
//  DATA_WIDTH   8   width of FIFO word and stream data
//  PKT_LEN      13  words per packet; m_last set on word PKT_LEN-1 (PKT_LEN>=1)
//  CNT_WIDTH    4   width of packet word counter; must hold PKT_LEN-1
// PORTS
//  clk          in   1           single clock, all logic on rising edge
//  reset        in   1           synchronous, active-low (0 = reset)
//  flush        in   1           sync clear of output buffer and packet counter
//  fifo_empty   in   1           FIFO empty flag
//  fifo_r_data  in   DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0
//  fifo_r_en    out  1           FIFO pop strobe
//  m_valid      out  1           stream word valid
//  m_ready      in   1           stream sink ready
//  m_data       out  DATA_WIDTH  stream word
//  m_last       out  1           last word of packet
//  pkt_done     out  1           1-cycle pulse when a word with m_last is accepted
// BEHAVIOUR
//  - Reset (reset=0 at edge): buffer count=0, packet counter=0; m_valid=0,
//    m_data=0, m_last=0, pkt_done=0, fifo_r_en=0 (fifo_r_en is combinational, low
//    while reset=0).
//  - fifo_r_en = reset & ~flush & ~fifo_empty & (count<2); depends only on
//    registered count, never on m_ready. Popped word written into buffer at the
//    same edge (fifo_r_data sampled with fifo_r_en).
//  - Buffer: 2-entry in-order (head + skid). m_valid = (count!=0); m_data = head.
//    Accept = m_valid & m_ready. Same-cycle pop and accept: count unchanged,
//    skid/new word moves to head. Order preserved in all cases.
//  - Latency: FIFO non-empty -> m_valid high 1 cycle later. Steady state with
//    m_ready=1: count sits at 1, one word per cycle, no bubbles.
//  - Backpressure: m_ready=0 -> buffer fills to 2, then fifo_r_en=0; m_data and
//    m_last stable while m_valid=1 and m_ready=0.
//  - Packet counter counts accepted words: m_last = m_valid & (cnt==PKT_LEN-1);
//    accepted word with m_last wraps cnt to 0 and pulses pkt_done next cycle.
//    PKT_LEN=1: m_last high on every valid word.
//  - FIFO empty mid-packet: m_valid drops, counter holds, packet resumes later.
//  - flush=1: count->0, cnt->0, pkt_done->0 next edge; no pop that cycle; words
//    in buffer are discarded. Accept in flush cycle is ignored by the counter.
//  - reset beats flush; reset mid-packet discards buffer and restarts counter.
//  - Count never exceeds 2; pop with count==2 is impossible by construction.
// CONFIGURATION
//  FIFO_RD_PARITY_EN defined: extra output m_parity (1 bit) = ^m_data, registered
//    with the buffer entry, reset 0, same valid/stability rules as m_data.
//  Not defined: port m_parity absent, no parity logic.
// TESTING
//  1 reset=0 3 cycles, FIFO holding data -> fifo_r_en=0, m_valid=0, m_last=0.
//  2 13 words 0x01..0x0D in FIFO, m_ready=1 -> 13 consecutive accepts, data in
//    order, m_last only on 0x0D, pkt_done pulse cycle after, count returns to 0.
//  3 m_ready=0 with 5 words queued -> exactly 2 pops, m_data=0x01 held stable;
//    m_ready=1 -> 0x01..0x05 back-to-back, no loss/duplication.
//  4 Random m_ready (50%) and random FIFO empty gaps over 1000 words -> scoreboard
//    matches, m_last every 13th accepted word, fifo_r_en never with fifo_empty=1.
//  5 flush on word 6 of a packet with 2 buffered -> m_valid=0 next cycle, next
//    accepted word has cnt 0 (m_last on 13th after flush).
//  6 FIFO_RD_PARITY_EN build: data 0x07 -> m_parity=1, 0x03 -> 0; reset -> 0.

Source files
------------

// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle for fifo_stream_reader: FIFO read side plus valid/ready stream side.
// The master modport is the reader; the slave modport is whatever surrounds it.
// Define FIFO_RD_PARITY_EN to add the m_parity stream signal.
interface fifo_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_r_data;
    logic                  fifo_r_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
`ifdef FIFO_RD_PARITY_EN
    logic                  m_parity;
`endif

    modport master (
        input  fifo_empty,
        input  fifo_r_data,
        input  m_ready,
        output fifo_r_en,
        output m_valid,
        output m_data,
`ifdef FIFO_RD_PARITY_EN
        output m_parity,
`endif
        output m_last
    );

    modport slave (
        output fifo_empty,
        output fifo_r_data,
        output m_ready,
        input  fifo_r_en,
        input  m_valid,
        input  m_data,
`ifdef FIFO_RD_PARITY_EN
        input  m_parity,
`endif
        input  m_last
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drain stage for a FIFO read port: pops words into a 2-entry in-order buffer
// (head + skid) and presents them on a valid/ready stream, marking every
// PKT_LEN-th accepted word with m_last. The pop strobe depends only on the
// registered buffer count, so m_ready never reaches fifo_r_en.
// Optional feature macro: FIFO_RD_PARITY_EN (adds m_parity = ^m_data).
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PKT_LEN    = 13,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    fifo_stream_reader_if.master bus,
    output logic                 pkt_done
);
    localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(PKT_LEN - 1);

    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  pkt_done_q, pkt_done_d;
    logic                  pop;
    logic                  accept;
    logic                  last;

    // Pop only while there is room; reset and flush both suppress it.
    assign pop           = reset & ~flush & ~bus.fifo_empty & (count_q != 2'd2);
    assign bus.fifo_r_en = pop;
    assign bus.m_valid   = (count_q != 2'd0);
    assign bus.m_data    = head_q;
    assign last          = bus.m_valid & (cnt_q == LastCnt);
    assign bus.m_last    = last;
    assign accept        = bus.m_valid & bus.m_ready;
    assign pkt_done      = pkt_done_q;

    // Next-state for the buffer and the packet word counter.
    always_comb begin
        count_d    = count_q;
        head_d     = head_q;
        skid_d     = skid_q;
        cnt_d      = cnt_q;
        pkt_done_d = 1'b0;
        if (flush) begin
            count_d = 2'd0;
            cnt_d   = '0;
        end else begin
            case ({pop, accept})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = bus.fifo_r_data;
                    end else begin
                        skid_d = bus.fifo_r_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = skid_q;
                    count_d = count_q - 2'd1;
                end
                // Pop and accept together only happen at count 1: new word replaces head.
                2'b11: head_d = bus.fifo_r_data;
                default: ;
            endcase
            if (accept) begin
                if (last) begin
                    cnt_d      = '0;
                    pkt_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q    <= 2'd0;
            head_q     <= '0;
            skid_q     <= '0;
            cnt_q      <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            cnt_q      <= cnt_d;
            pkt_done_q <= pkt_done_d;
        end
    end

`ifdef FIFO_RD_PARITY_EN
    logic head_par_q, head_par_d;
    logic skid_par_q, skid_par_d;
    logic in_par;

    assign in_par       = ^bus.fifo_r_data;
    assign bus.m_parity = head_par_q;

    // Parity bits follow their data words through head/skid.
    always_comb begin
        head_par_d = head_par_q;
        skid_par_d = skid_par_q;
        if (!flush) begin
            case ({pop, accept})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_par_d = in_par;
                    end else begin
                        skid_par_d = in_par;
                    end
                end
                2'b01:   head_par_d = skid_par_q;
                2'b11:   head_par_d = in_par;
                default: ;
            endcase
        end
    end

    // Parity registers, cleared with the data buffer on reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_par_q <= 1'b0;
            skid_par_q <= 1'b0;
        end else begin
            head_par_q <= head_par_d;
            skid_par_q <= skid_par_d;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and randomised bench for fifo_stream_reader with a queue-based FIFO model.
`timescale 1ns/1ps
module tb_fifo_stream_reader;
    localparam int unsigned DW  = 8;
    localparam int unsigned PKT = 13;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic pkt_done;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_reader #(
        .DATA_WIDTH(DW),
        .PKT_LEN   (PKT),
        .CNT_WIDTH (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .bus     (bus),
        .pkt_done(pkt_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] sb[$];

    logic          s_pop, s_valid, s_ready, s_acc, s_last, s_pkt, s_empty;
    logic [DW-1:0] s_data;
`ifdef FIFO_RD_PARITY_EN
    logic          s_par;
`endif

    task automatic fifo_update();
        bus.fifo_empty  = (fq.size() == 0);
        bus.fifo_r_data = (fq.size() != 0) ? fq[0] : '0;
    endtask

    // Sample outputs at the falling edge, then advance past the rising edge
    // and pop the model FIFO if the DUT strobed fifo_r_en.
    task automatic step();
        @(negedge clk);
        s_pop   = bus.fifo_r_en;
        s_valid = bus.m_valid;
        s_ready = bus.m_ready;
        s_acc   = bus.m_valid & bus.m_ready;
        s_data  = bus.m_data;
        s_last  = bus.m_last;
        s_pkt   = pkt_done;
        s_empty = bus.fifo_empty;
`ifdef FIFO_RD_PARITY_EN
        s_par   = bus.m_parity;
`endif
        @(posedge clk);
        #1;
        if (s_pop && fq.size() != 0) void'(fq.pop_front());
        fifo_update();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        flush = 1'b1;
        bus.m_ready = 1'b1;
        fq.delete();
        for (int i = 0; i < 3; i++) fq.push_back(DW'(8'hA0 + i));
        fifo_update();
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (s_pop !== 1'b0 || s_valid !== 1'b0 || s_last !== 1'b0 ||
                s_data !== '0 || s_pkt !== 1'b0) begin
                failures++;
                $display("FAIL reset cyc%0d: r_en=%b valid=%b last=%b data=%h pkt=%b, need all 0",
                         c, s_pop, s_valid, s_last, s_data, s_pkt);
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_packet();
        int n = 0, cyc = 0, first = -1, lastc = -1;
        fq.delete();
        for (int i = 1; i <= 13; i++) fq.push_back(DW'(i));
        fifo_update();
        bus.m_ready = 1'b1;
        reset = 1'b1;
        while (n < 13 && cyc < 60) begin
            step();
            cyc++;
            if (s_acc) begin
                checks++;
                if (s_data !== DW'(n + 1) || s_last !== (n == 12)) begin
                    failures++;
                    $display("FAIL packet word%0d: data=%h last=%b, need data=%h last=%b",
                             n, s_data, s_last, DW'(n + 1), (n == 12));
                end
                if (n == 0) first = cyc;
                lastc = cyc;
                n++;
            end
        end
        checks++;
        if (n != 13 || lastc - first != 12) begin
            failures++;
            $display("FAIL packet run: accepts=%0d span=%0d, need 13 accepts span 12",
                     n, lastc - first);
        end
        step();
        checks++;
        if (s_pkt !== 1'b1 || s_valid !== 1'b0) begin
            failures++;
            $display("FAIL packet pkt_done: pkt=%b valid=%b, need pkt=1 valid=0", s_pkt, s_valid);
        end
        step();
        checks++;
        if (s_pkt !== 1'b0) begin
            failures++;
            $display("FAIL packet pulse width: pkt=%b, need 0", s_pkt);
        end
    endtask

    task automatic test_backpressure();
        int pops = 0, n = 0, cyc = 0, first = -1, lastc = -1;
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) fq.push_back(DW'(i));
        fifo_update();
        for (int c = 0; c < 6; c++) begin
            step();
            if (s_pop) pops++;
            if (s_valid) begin
                checks++;
                if (s_data !== DW'(1) || s_last !== 1'b0) begin
                    failures++;
                    $display("FAIL hold cyc%0d: data=%h last=%b, need data=01 last=0",
                             c, s_data, s_last);
                end
            end
        end
        checks++;
        if (pops != 2) begin
            failures++;
            $display("FAIL hold pops: got %0d, need 2", pops);
        end
        bus.m_ready = 1'b1;
        while (n < 5 && cyc < 30) begin
            step();
            cyc++;
            if (s_pop) pops++;
            if (s_acc) begin
                checks++;
                if (s_data !== DW'(n + 1)) begin
                    failures++;
                    $display("FAIL drain word%0d: data=%h, need %h", n, s_data, DW'(n + 1));
                end
                if (n == 0) first = cyc;
                lastc = cyc;
                n++;
            end
        end
        checks++;
        if (n != 5 || lastc - first != 4 || pops != 5 || fq.size() != 0) begin
            failures++;
            $display("FAIL drain run: accepts=%0d span=%0d pops=%0d left=%0d, need 5/4/5/0",
                     n, lastc - first, pops, fq.size());
        end
    endtask

    task automatic test_flush();
        int n = 0, cyc = 0;
        // Five words of the current packet already accepted; next one is word 6.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 15; i++) fq.push_back(DW'(8'h20 + i));
        fifo_update();
        repeat (3) step();
        checks++;
        if (s_pop !== 1'b0 || s_valid !== 1'b1 || s_data !== DW'(8'h20)) begin
            failures++;
            $display("FAIL flush setup: r_en=%b valid=%b data=%h, need 0/1/20",
                     s_pop, s_valid, s_data);
        end
        flush = 1'b1;
        bus.m_ready = 1'b1;
        step();
        checks++;
        if (s_pop !== 1'b0) begin
            failures++;
            $display("FAIL flush r_en: got %b, need 0", s_pop);
        end
        flush = 1'b0;
        step();
        checks++;
        if (s_valid !== 1'b0 || s_pkt !== 1'b0) begin
            failures++;
            $display("FAIL flush clear: valid=%b pkt=%b, need 0/0", s_valid, s_pkt);
        end
        while (n < 13 && cyc < 60) begin
            step();
            cyc++;
            if (s_acc) begin
                checks++;
                if (s_data !== DW'(8'h22 + n) || s_last !== (n == 12)) begin
                    failures++;
                    $display("FAIL post-flush word%0d: data=%h last=%b, need data=%h last=%b",
                             n, s_data, s_last, DW'(8'h22 + n), (n == 12));
                end
                n++;
            end
        end
        step();
        checks++;
        if (n != 13 || s_pkt !== 1'b1) begin
            failures++;
            $display("FAIL post-flush packet: accepts=%0d pkt=%b, need 13/1", n, s_pkt);
        end
    endtask

    task automatic test_random();
        int            pushed = 0, acc_n = 0, mcnt = 0, cyc = 0;
        logic          exp_pkt = 1'b0, prev_hold = 1'b0, prev_l = 1'b0;
        logic [DW-1:0] prev_d = '0, exp_d;
        sb.delete();
        while (acc_n < 1000 && cyc < 20000) begin
            if (pushed < 1000 && $urandom_range(0, 9) < 6) begin
                fq.push_back(DW'(pushed * 7 + 3));
                sb.push_back(DW'(pushed * 7 + 3));
                pushed++;
                fifo_update();
            end
            bus.m_ready = 1'($urandom_range(0, 1));
            step();
            cyc++;
            checks++;
            if (s_pop && s_empty) begin
                failures++;
                $display("FAIL rand r_en_on_empty cyc%0d: r_en=1 empty=1", cyc);
            end
            checks++;
            if (s_pkt !== exp_pkt || (!s_valid && s_last !== 1'b0)) begin
                failures++;
                $display("FAIL rand pkt cyc%0d: pkt=%b last=%b valid=%b, need pkt=%b",
                         cyc, s_pkt, s_last, s_valid, exp_pkt);
            end
            if (prev_hold) begin
                checks++;
                if (s_valid !== 1'b1 || s_data !== prev_d || s_last !== prev_l) begin
                    failures++;
                    $display("FAIL rand stable cyc%0d: valid=%b data=%h last=%b, need 1/%h/%b",
                             cyc, s_valid, s_data, s_last, prev_d, prev_l);
                end
            end
            exp_pkt = 1'b0;
            if (s_acc) begin
                checks++;
                exp_d = (sb.size() != 0) ? sb.pop_front() : '0;
                if (s_data !== exp_d || s_last !== (mcnt == PKT - 1)) begin
                    failures++;
                    $display("FAIL rand word%0d: data=%h last=%b, need data=%h last=%b",
                             acc_n, s_data, s_last, exp_d, (mcnt == PKT - 1));
                end
                if (mcnt == PKT - 1) begin
                    mcnt    = 0;
                    exp_pkt = 1'b1;
                end else begin
                    mcnt++;
                end
                acc_n++;
            end
            prev_hold = s_valid && !s_ready;
            prev_d    = s_data;
            prev_l    = s_last;
        end
        checks++;
        if (acc_n != 1000 || sb.size() != 0) begin
            failures++;
            $display("FAIL rand total: accepts=%0d left=%0d, need 1000/0", acc_n, sb.size());
        end
    endtask

`ifdef FIFO_RD_PARITY_EN
    task automatic test_parity();
        bus.m_ready = 1'b0;
        fq.push_back(DW'(8'h07));
        fq.push_back(DW'(8'h03));
        fifo_update();
        repeat (3) step();
        checks++;
        if (s_data !== DW'(8'h07) || s_par !== 1'b1) begin
            failures++;
            $display("FAIL parity 07: data=%h par=%b, need 07/1", s_data, s_par);
        end
        bus.m_ready = 1'b1;
        step();
        step();
        checks++;
        if (s_data !== DW'(8'h03) || s_par !== 1'b0) begin
            failures++;
            $display("FAIL parity 03: data=%h par=%b, need 03/0", s_data, s_par);
        end
        reset = 1'b0;
        bus.m_ready = 1'b0;
        fq.push_back(DW'(8'h07));
        fifo_update();
        step();
        checks++;
        if (s_par !== 1'b0 || s_valid !== 1'b0) begin
            failures++;
            $display("FAIL parity reset: par=%b valid=%b, need 0/0", s_par, s_valid);
        end
        reset = 1'b1;
    endtask
`endif

    initial begin
        reset           = 1'b0;
        flush           = 1'b0;
        bus.m_ready     = 1'b0;
        bus.fifo_empty  = 1'b1;
        bus.fifo_r_data = '0;
        test_reset();
        test_packet();
        test_backpressure();
        test_flush();
        test_random();
`ifdef FIFO_RD_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
